wb_stage_trace: RTL and testbench

Parametrised writeback stage: the last pipeline stage of the CPU. It accepts one instruction per cycle from MEM and emits byte-masked register-file writes to ID. It keeps a retired-instruction counter and presents the difftest/debug trace through a small decoupling FIFO with a valid/ready handshake. A trace sink that cannot keep up back-pressures the pipeline instead of losing retirements.

---
 rtl/wb_stage_trace.sv | 147 ++++++++++++++
 tb/tb_wb_stage_trace.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_trace.sv
// Writeback stage: final pipeline stage. Captures one instruction per cycle
// from MEM, drives byte-masked register-file writes back to ID, counts
// retirements and publishes a difftest/debug trace.
// Optional feature macro: WB_TRACE_FIFO_EN
//   defined   - trace goes through a small valid/ready FIFO; a slow trace sink
//               back-pressures the pipeline instead of losing retirements.
//   undefined - no trace storage; the trace mirrors the stage register.
module wb_stage_trace #(
    parameter int DATA_W     = 32,
    parameter int RF_AW      = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                                        clk,
    input  logic                                        reset,
    output logic                                        wb_allow_in,
    input  logic                                        mem_to_wb_valid,
    input  logic [2*DATA_W+DATA_W/8+RF_AW-1:0]          mem_to_wb_bus,
    output logic [DATA_W/8+RF_AW+DATA_W-1:0]            wb_to_id_bus,
    output logic [CNT_W-1:0]                            wb_retire_cnt,
    output logic                                        debug_wb_valid,
    input  logic                                        debug_wb_ready,
    output logic [DATA_W-1:0]                           debug_wb_pc,
    output logic [DATA_W/8-1:0]                         debug_wb_rf_we,
    output logic [RF_AW-1:0]                            debug_wb_rf_wnum,
    output logic [DATA_W-1:0]                           debug_wb_rf_wdata
);

    localparam int BYTES = DATA_W / 8;
    localparam int BUS_W = 2 * DATA_W + BYTES + RF_AW;

    logic                 wb_valid_q;
    logic [BUS_W-1:0]     wb_reg_q;
    logic [DATA_W-1:0]    wb_pc;
    logic [DATA_W-1:0]    wb_result;
    logic [BYTES-1:0]     wb_we;
    logic [RF_AW-1:0]     wb_waddr;
    logic                 wb_ready_go;
    logic                 retire;
    logic [BYTES-1:0]     rf_we;
    logic [CNT_W-1:0]     retire_cnt_q;

    assign {wb_pc, wb_result, wb_we, wb_waddr} = wb_reg_q;

    assign wb_allow_in = !wb_valid_q || wb_ready_go;
    assign retire      = wb_valid_q && wb_ready_go;

    // Stage valid bit: follows MEM whenever the stage can take a new instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
        end else if (wb_allow_in) begin
            wb_valid_q <= mem_to_wb_valid;
        end
    end

    // Stage payload: only loaded on an actual transfer; contents are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (wb_allow_in && mem_to_wb_valid) begin
            wb_reg_q <= mem_to_wb_bus;
        end
    end

    // A stalled or empty stage must never write the register file.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_rf_we
        assign rf_we[gi] = retire & wb_we[gi];
    end

    assign wb_to_id_bus = {rf_we, wb_waddr, wb_result};

    // Retirement counter, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else if (retire) begin
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

    assign wb_retire_cnt = retire_cnt_q;

`ifdef WB_TRACE_FIFO_EN
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = DATA_W + BYTES + RF_AW + DATA_W;

    logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [ENT_W-1:0] fifo_head;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);

    // When full, retiring is still allowed if the head leaves in the same cycle.
    assign wb_ready_go = !fifo_full || debug_wb_ready;
    assign fifo_push   = retire;
    assign fifo_pop    = !fifo_empty && debug_wb_ready;

    // Trace storage: every retirement is recorded, even with no register write.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= {wb_pc, wb_we, wb_waddr, wb_result};
        end
    end

    // Read/write pointers; reset discards any queued entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Head is shown directly so it stays stable while the sink holds off;
    // an empty FIFO presents all-zero fields.
    assign fifo_head      = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign debug_wb_valid = !fifo_empty;
    assign {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata} = fifo_head;
`else
    logic unused_debug_ready;

    assign unused_debug_ready = debug_wb_ready;
    assign wb_ready_go        = 1'b1;
    assign debug_wb_valid     = wb_valid_q;
    assign debug_wb_pc        = wb_pc;
    assign debug_wb_rf_wnum   = wb_waddr;
    assign debug_wb_rf_wdata  = wb_result;

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_dbg_we
        assign debug_wb_rf_we[gi] = wb_valid_q & wb_we[gi];
    end
`endif

endmodule

// File: tb/tb_wb_stage_trace.sv
// Scoreboard bench for wb_stage_trace: accepted instructions are queued as
// expected register writes and trace entries, and popped as the DUT emits them.
`timescale 1ns/1ps
module tb_wb_stage_trace;

    localparam int DATA_W     = 32;
    localparam int RF_AW      = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 4;
    localparam int BYTES      = DATA_W / 8;
`ifdef WB_TRACE_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
        logic [3:0]  we;
        logic [4:0]  wa;
    } instr_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 wb_allow_in;
    logic                 mem_to_wb_valid;
    logic [72:0]          mem_to_wb_bus;
    logic [40:0]          wb_to_id_bus;
    logic [CNT_W-1:0]     wb_retire_cnt;
    logic                 debug_wb_valid;
    logic                 debug_wb_ready;
    logic [31:0]          debug_wb_pc;
    logic [3:0]           debug_wb_rf_we;
    logic [4:0]           debug_wb_rf_wnum;
    logic [31:0]          debug_wb_rf_wdata;

    always #5 clk = ~clk;

    wb_stage_trace #(
        .DATA_W(DATA_W), .RF_AW(RF_AW), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wb_allow_in(wb_allow_in),
        .mem_to_wb_valid(mem_to_wb_valid),
        .mem_to_wb_bus(mem_to_wb_bus),
        .wb_to_id_bus(wb_to_id_bus),
        .wb_retire_cnt(wb_retire_cnt),
        .debug_wb_valid(debug_wb_valid),
        .debug_wb_ready(debug_wb_ready),
        .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    instr_t stim_q[$];
    instr_t rf_q[$];
    instr_t trace_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     n_acc = 0;
    int     n_wr  = 0;
    int     n_tr  = 0;
    bit     drv_acc;
    instr_t drv_s;
    instr_t mon_e;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver: samples acceptance just before the edge, updates the scoreboard
    // just after it, then presents the next queued instruction.
    initial begin
        mem_to_wb_valid = 1'b0;
        mem_to_wb_bus   = '0;
        forever begin
            @(negedge clk); #4;
            drv_acc = mem_to_wb_valid && wb_allow_in && !reset;
            @(posedge clk); #1;
            if (drv_acc && stim_q.size() > 0) begin
                drv_s = stim_q.pop_front();
                n_acc++;
                if (drv_s.we != 4'h0) rf_q.push_back(drv_s);
                trace_q.push_back(drv_s);
            end
            if (stim_q.size() > 0) begin
                mem_to_wb_valid = 1'b1;
                mem_to_wb_bus   = stim_q[0];
            end else begin
                mem_to_wb_valid = 1'b0;
                mem_to_wb_bus   = '0;
            end
        end
    end

    // Monitor: register writes and trace handshakes, sampled just before the edge.
    initial begin
        forever begin
            @(negedge clk); #4;
            if (!reset) begin
                if (wb_to_id_bus[40:37] != 4'h0) begin
                    n_wr++;
                    if (rf_q.size() == 0) begin
                        check_val("rf_extra", wb_to_id_bus[40:37], 0);
                    end else begin
                        mon_e = rf_q.pop_front();
                        check_val("rf_we",   wb_to_id_bus[40:37], mon_e.we);
                        check_val("rf_addr", wb_to_id_bus[36:32], mon_e.wa);
                        check_val("rf_data", wb_to_id_bus[31:0],  mon_e.res);
                    end
                end
                if (debug_wb_valid && (debug_wb_ready || !FIFO_EN)) begin
                    n_tr++;
                    $display("trace pc=%h we=%h wnum=%0d wdata=%h cnt=%0d",
                             debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, wb_retire_cnt);
                    if (trace_q.size() == 0) begin
                        check_val("trace_extra", debug_wb_valid, 0);
                    end else begin
                        mon_e = trace_q.pop_front();
                        check_val("tr_pc",   debug_wb_pc,       mon_e.pc);
                        check_val("tr_we",   debug_wb_rf_we,    mon_e.we);
                        check_val("tr_wnum", debug_wb_rf_wnum,  mon_e.wa);
                        check_val("tr_data", debug_wb_rf_wdata, mon_e.res);
                    end
                end
`ifdef WB_TRACE_FIFO_EN
                if (!debug_wb_valid) begin
                    check_val("dbg_idle_zero",
                              {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata}, 0);
                end
`endif
            end
        end
    end

    // Main-sequence actions happen at negedge+2, checks at negedge+3.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic apply_reset(input int cyc);
        step(1);
        reset = 1'b1;
        stim_q.delete();
        rf_q.delete();
        trace_q.delete();
        n_acc = 0;
        step(cyc);
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((stim_q.size() + rf_q.size() + trace_q.size()) != 0 && n < 300) begin
            step(1);
            n++;
        end
        check_val(tag, stim_q.size() + rf_q.size() + trace_q.size(), 0);
        step(2);
    endtask

    initial begin
        int first, last, nw, snap;
        bit drop;
        debug_wb_ready = 1'b1;

        // Reset state
        apply_reset(2);
        #1;
        check_val("rst_allow_in", wb_allow_in, 1);
        check_val("rst_cnt", wb_retire_cnt, 0);
        check_val("rst_dbg_valid", debug_wb_valid, 0);
        check_val("rst_rf_we", wb_to_id_bus[40:37], 0);
`ifdef WB_TRACE_FIFO_EN
        check_val("rst_dbg_fields", {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata}, 0);
`endif

        // Streaming: 8 back-to-back full-word writes
        step(1);
        for (int i = 0; i < 8; i++)
            stim_q.push_back(instr_t'{pc: 32'h1c000000 + 32'(4 * i), res: $urandom, we: 4'hF, wa: 5'(i + 1)});
        first = -1; last = -1; nw = 0; drop = 1'b0;
        for (int c = 0; c < 14; c++) begin
            step(1);
            #1;
            if (!wb_allow_in) drop = 1'b1;
            if (wb_to_id_bus[40:37] != 4'h0) begin
                nw++;
                if (first < 0) first = c;
                last = c;
            end
        end
        check_val("stream_allow_drop", drop, 0);
        check_val("stream_writes", nw, 8);
        check_val("stream_span", last - first + 1, 8);
        drain("stream_drain");
        check_val("stream_cnt", wb_retire_cnt, 8);

        // Back-pressure: sink stalled while 6 instructions arrive
        debug_wb_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            stim_q.push_back(instr_t'{pc: 32'h1c001000 + 32'(4 * i), res: $urandom, we: 4'hF, wa: 5'(10 + i)});
        step(12);
`ifdef WB_TRACE_FIFO_EN
        #1;
        check_val("bp_allow_in", wb_allow_in, 0);
        check_val("bp_rf_we", wb_to_id_bus[40:37], 0);
        check_val("bp_dbg_valid", debug_wb_valid, 1);
        check_val("bp_head_pc", debug_wb_pc, 32'h1c001000);
        check_val("bp_accepted", n_acc, 5);
        check_val("bp_cnt", wb_retire_cnt, 12);
        // Full FIFO, sink ready: push and pop together
        step(1);
        debug_wb_ready = 1'b1;
        #1;
        check_val("full_pp_allow_in", wb_allow_in, 1);
        step(1);
        debug_wb_ready = 1'b0;
        #1;
        check_val("full_pp_still_full", wb_allow_in, 0);
        check_val("full_pp_head_pc", debug_wb_pc, 32'h1c001004);
        check_val("full_pp_accepted", n_acc, 6);
        check_val("full_pp_cnt", wb_retire_cnt, 13);
`endif
        debug_wb_ready = 1'b1;
        drain("bp_drain");
        check_val("bp_final_cnt", wb_retire_cnt, 14);

        // Partial write and no-write instruction
        nw = n_wr; snap = n_tr;
        stim_q.push_back(instr_t'{pc: 32'h1c002000, res: 32'hDEADBEEF, we: 4'h3, wa: 5'd7});
        stim_q.push_back(instr_t'{pc: 32'h1c002004, res: 32'h12345678, we: 4'h0, wa: 5'd8});
        drain("partial_drain");
        check_val("partial_writes", n_wr - nw, 1);
        check_val("partial_traces", n_tr - snap, 2);
        check_val("partial_cnt", wb_retire_cnt, 0);

        // Counter wrap: 17 retirements on a 4-bit counter
        apply_reset(2);
        for (int i = 0; i < 17; i++)
            stim_q.push_back(instr_t'{pc: 32'h1c003000 + 32'(4 * i), res: $urandom, we: 4'(i), wa: 5'(i)});
        drain("wrap_drain");
        check_val("wrap_cnt", wb_retire_cnt, 1);

        // Reset with trace entries pending
        debug_wb_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            stim_q.push_back(instr_t'{pc: 32'h1c004000 + 32'(4 * i), res: $urandom, we: 4'hF, wa: 5'(20 + i)});
        step(6);
`ifdef WB_TRACE_FIFO_EN
        #1;
        check_val("pend_dbg_valid", debug_wb_valid, 1);
`endif
        apply_reset(1);
        #1;
        check_val("rst2_dbg_valid", debug_wb_valid, 0);
        check_val("rst2_cnt", wb_retire_cnt, 0);
        check_val("rst2_allow_in", wb_allow_in, 1);
        snap = n_tr;
        debug_wb_ready = 1'b1;
        step(10);
        check_val("rst2_no_emit", n_tr - snap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
